mem_access_unit: RTL and testbench

Load/store bridge between the multicycle datapath/controller and the word-organised on-chip data memory (BRAM/SPRAM).
- Accepts one access request at a time: address, funct3, store data.
- Drives the memory with a word address, byte-lane write mask and lane-replicated write data.
- Waits a parameterised read latency, then returns load data extracted from the addressed lanes and sign- or zero-extended.
- Flags misaligned or illegal accesses without touching memory.

---
 rtl/mem_access_unit_if.sv | 34 +++
 rtl/mem_access_unit.sv | 219 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Bus bundle for the load/store bridge. The master side is the datapath
// plus the data memory; the slave side is the bridge itself.
interface mem_access_unit_if #(
  parameter int ADDR_W = 12
);
  // Request side, from the multicycle controller
  logic              req;
  logic              we;
  logic [2:0]        funct3;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [31:0]       rdata;

  // Memory side, to the word-organised data RAM
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ren;
  logic              mem_wen;
  logic [3:0]        mem_wmask;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    output req, we, funct3, addr, wdata, mem_rdata,
    input  busy, done, err, rdata, mem_addr, mem_ren, mem_wen, mem_wmask, mem_wdata
  );

  modport slave (
    input  req, we, funct3, addr, wdata, mem_rdata,
    output busy, done, err, rdata, mem_addr, mem_ren, mem_wen, mem_wmask, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store bridge between the multicycle datapath and a word-organised
// data memory. One access at a time; stores drive a byte-lane mask with
// lane-replicated data, loads wait MEM_LATENCY cycles and return the
// addressed byte/half/word sign- or zero-extended. Misaligned or illegal
// requests complete with err=1 without touching memory.
module mem_access_unit #(
  parameter int ADDR_W      = 12,
  parameter int MEM_LATENCY = 1   // legal range 1..7
) (
  input  logic             clk,
  input  logic             reset,   // asynchronous, active low
  mem_access_unit_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_WAIT,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  // Captured request fields needed after IDLE
  logic [2:0]        r_funct3;
  logic [1:0]        r_addr_lo;
  logic [2:0]        r_cnt;

  // Registered outputs
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [31:0]       r_rdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_ren;
  logic              r_mem_wen;
  logic [3:0]        r_mem_wmask;
  logic [31:0]       r_mem_wdata;

  // Next values of the strobe-like outputs, decided with the next state
  logic              w_busy_next;
  logic              w_done_next;
  logic              w_err_next;
  logic              w_mem_ren_next;
  logic              w_mem_wen_next;

  logic              w_accept;
  logic              w_illegal;
  logic              w_misaligned;
  logic              w_bad;
  logic [31:0]       w_st_wdata;
  logic [3:0]        w_st_wmask;
  logic [31:0]       w_shifted;
  logic [31:0]       w_load_data;

  assign w_accept = (r_state == ST_IDLE) && bus.req;

  // Classify the request on the bus as illegal and/or misaligned
  always_comb begin
    w_illegal    = 1'b0;
    w_misaligned = 1'b0;
    if (bus.we) begin
      w_illegal = !(bus.funct3 inside {3'b000, 3'b001, 3'b010});
    end else begin
      w_illegal = !(bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end
    case (bus.funct3[1:0])
      2'b01:   w_misaligned = bus.addr[0];
      2'b10:   w_misaligned = (bus.addr[1:0] != 2'b00);
      default: w_misaligned = 1'b0;
    endcase
  end

  assign w_bad = w_illegal | w_misaligned;

  // Per-lane store data and enable: bytes are copied to every lane, halves
  // to both half-lanes, and the mask picks the lanes that actually change.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic [7:0] w_lane_data;
      logic       w_lane_en;

      // Select this lane's byte and enable from the width code and address
      always_comb begin
        w_lane_data = bus.wdata[8*gi +: 8];
        w_lane_en   = 1'b1;
        case (bus.funct3[1:0])
          2'b00: begin
            w_lane_data = bus.wdata[7:0];
            w_lane_en   = (bus.addr[1:0] == LANE);
          end
          2'b01: begin
            w_lane_data = LANE[0] ? bus.wdata[15:8] : bus.wdata[7:0];
            w_lane_en   = (bus.addr[1] == LANE[1]);
          end
          default: begin
            w_lane_data = bus.wdata[8*gi +: 8];
            w_lane_en   = 1'b1;
          end
        endcase
      end

      assign w_st_wdata[8*gi +: 8] = w_lane_data;
      assign w_st_wmask[gi]        = w_lane_en;
    end
  endgenerate

  // Bring the addressed byte/half down to bit 0 of the returned word
  assign w_shifted = bus.mem_rdata >> {r_addr_lo, 3'b000};

  // Extend the selected byte/half according to the captured width code
  always_comb begin
    w_load_data = w_shifted;
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b100:  w_load_data = {24'h000000, w_shifted[7:0]};
      3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b101:  w_load_data = {16'h0000, w_shifted[15:0]};
      default: w_load_data = w_shifted;
    endcase
  end

  // Next-state and next-output decode for the access sequencer
  always_comb begin
    w_state_next   = r_state;
    w_err_next     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.req) begin
          if (w_bad) begin
            w_state_next = ST_DONE;
            w_err_next   = 1'b1;
          end else if (bus.we) begin
            w_state_next = ST_WRITE;
          end else begin
            w_state_next = ST_READ;
          end
        end
      end
      ST_WRITE:   w_state_next = ST_DONE;
      ST_READ:    w_state_next = (MEM_LATENCY == 1) ? ST_CAPTURE : ST_WAIT;
      ST_WAIT:    if (r_cnt <= 3'd1) w_state_next = ST_CAPTURE;
      ST_CAPTURE: w_state_next = ST_DONE;
      ST_DONE:    w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
    w_busy_next    = (w_state_next != ST_IDLE);
    w_done_next    = (w_state_next == ST_DONE);
    w_mem_ren_next = (w_state_next == ST_READ);
    w_mem_wen_next = (w_state_next == ST_WRITE);
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Request capture, latency counter and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_funct3    <= '0;
      r_addr_lo   <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_ren   <= 1'b0;
      r_mem_wen   <= 1'b0;
      r_mem_wmask <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
      r_err     <= w_err_next;
      r_mem_ren <= w_mem_ren_next;
      r_mem_wen <= w_mem_wen_next;
      // Mask is only non-zero alongside the write strobe
      r_mem_wmask <= w_mem_wen_next ? w_st_wmask : 4'b0000;

      if (w_accept) begin
        r_funct3    <= bus.funct3;
        r_addr_lo   <= bus.addr[1:0];
        r_mem_addr  <= bus.addr[ADDR_W+1:2];
        r_mem_wdata <= w_st_wdata;
      end

      if (r_state == ST_READ) begin
        r_cnt <= 3'(MEM_LATENCY - 1);
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - 3'd1;
      end

      if (r_state == ST_CAPTURE) begin
        r_rdata <= w_load_data;
      end
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.rdata     = r_rdata;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_ren   = r_mem_ren;
  assign bus.mem_wen   = r_mem_wen;
  assign bus.mem_wmask = r_mem_wmask;
  assign bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: two instances (MEM_LATENCY 1 and 2)
// receive identical requests; each has its own latency-accurate memory
// responder and expectation queue, compared when done pulses.
module tb_mem_access_unit;
  localparam int ADDR_W = 12;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(ADDR_W)) bus1 ();
  mem_access_unit_if #(.ADDR_W(ADDR_W)) bus2 ();

  mem_access_unit #(.ADDR_W(ADDR_W), .MEM_LATENCY(1)) dut1 (
    .clk   (clk),
    .reset (reset_n),
    .bus   (bus1)
  );

  mem_access_unit #(.ADDR_W(ADDR_W), .MEM_LATENCY(2)) dut2 (
    .clk   (clk),
    .reset (reset_n),
    .bus   (bus2)
  );

  typedef struct {
    logic        is_load;
    logic        is_store;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [11:0] maddr;
    int          lat;
    int          t_acc;
  } exp_t;

  exp_t        q1[$];
  exp_t        q2[$];
  exp_t        h1, h2;
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          nren[2] = '{0, 0};
  int          nwen[2] = '{0, 0};
  int          m1_cnt = 0;
  int          m2_cnt = 0;
  logic [31:0] last_rdata = 32'h0;
  logic [31:0] mem_words [16];

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responders: data valid exactly L cycles after the mem_ren cycle
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       m1_cnt <= 0;
    else if (bus1.mem_ren)              m1_cnt <= 1;
    else if (m1_cnt != 0 && m1_cnt < 8) m1_cnt <= m1_cnt + 1;
  end
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       m2_cnt <= 0;
    else if (bus2.mem_ren)              m2_cnt <= 1;
    else if (m2_cnt != 0 && m2_cnt < 8) m2_cnt <= m2_cnt + 1;
  end
  assign bus1.mem_rdata = (m1_cnt == 1) ? mem_words[bus1.mem_addr[3:0]] : 32'hDEADBEEF;
  assign bus2.mem_rdata = (m2_cnt == 2) ? mem_words[bus2.mem_addr[3:0]] : 32'hDEADBEEF;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input int lat_l, input logic [31:0] prev);
    exp_t        e;
    logic [31:0] word;
    logic [7:0]  b;
    logic [15:0] h;
    logic        ill, mis;
    word = mem_words[a[5:2]];
    case (a[1:0])
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h   = a[1] ? word[31:16] : word[15:0];
    ill = we ? (f3 > 3'd2)
             : !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    mis = ((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'd0);
    e.is_load  = !we;
    e.is_store = we;
    e.err      = ill | mis;
    e.rdata    = prev;
    e.wmask    = 4'b0000;
    e.wdata    = 32'h0;
    e.maddr    = a[13:2];
    e.t_acc    = 0;
    if (e.err) begin
      e.lat = 1;
    end else if (we) begin
      e.lat = 2;
      case (f3)
        3'd0: begin
          e.wdata = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
          case (a[1:0])
            2'd0:    e.wmask = 4'b0001;
            2'd1:    e.wmask = 4'b0010;
            2'd2:    e.wmask = 4'b0100;
            default: e.wmask = 4'b1000;
          endcase
        end
        3'd1: begin
          e.wdata = {wd[15:0], wd[15:0]};
          e.wmask = a[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          e.wdata = wd;
          e.wmask = 4'b1111;
        end
      endcase
    end else begin
      e.lat = 2 + lat_l;
      case (f3)
        3'd0:    e.rdata = {{24{b[7]}}, b};
        3'd4:    e.rdata = {24'h0, b};
        3'd1:    e.rdata = {{16{h[15]}}, h};
        3'd5:    e.rdata = {16'h0, h};
        default: e.rdata = word;
      endcase
    end
    return e;
  endfunction

  // Per-instance observation: memory strobes checked against the head
  // expectation, completions popped and compared
  task automatic monitor_dut(input int idx, input logic done, input logic err,
                             input logic [31:0] rdata, input logic ren, input logic wen,
                             input logic [3:0] wmask, input logic [31:0] wdata,
                             input logic [11:0] maddr);
    exp_t e;
    int   sz;
    sz = (idx == 0) ? q1.size() : q2.size();
    if (sz != 0) e = (idx == 0) ? q1[0] : q2[0];
    if (ren && wen) check("ren_wen_excl", {31'b0, ren & wen}, 32'h0);
    if (wen) begin
      nwen[idx]++;
      if (sz != 0) begin
        check("wmask", {28'b0, wmask}, {28'b0, e.wmask});
        check("wdata", wdata, e.wdata);
        check("waddr", {20'b0, maddr}, {20'b0, e.maddr});
      end
    end
    if (ren) begin
      nren[idx]++;
      if (sz != 0) check("raddr", {20'b0, maddr}, {20'b0, e.maddr});
    end
    if (done) begin
      if (sz == 0) begin
        check("spurious_done", {31'b0, done}, 32'h0);
      end else begin
        if (idx == 0) void'(q1.pop_front());
        else          void'(q2.pop_front());
        check("err", {31'b0, err}, {31'b0, e.err});
        check("rdata", rdata, e.rdata);
        check("latency", cyc - e.t_acc, e.lat);
        check("nren", nren[idx], (e.is_load && !e.err) ? 1 : 0);
        check("nwen", nwen[idx], (e.is_store && !e.err) ? 1 : 0);
        $display("dut%0d txn load=%0b err=%0b rdata=%08h latency=%0d", idx + 1,
                 e.is_load, err, rdata, cyc - e.t_acc);
      end
      nren[idx] = 0;
      nwen[idx] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      monitor_dut(0, bus1.done, bus1.err, bus1.rdata, bus1.mem_ren, bus1.mem_wen,
                  bus1.mem_wmask, bus1.mem_wdata, bus1.mem_addr);
      monitor_dut(1, bus2.done, bus2.err, bus2.rdata, bus2.mem_ren, bus2.mem_wen,
                  bus2.mem_wmask, bus2.mem_wdata, bus2.mem_addr);
    end
  end

  task automatic set_req(input logic v, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
    bus1.req = v; bus1.we = we; bus1.funct3 = f3; bus1.addr = a; bus1.wdata = wd;
    bus2.req = v; bus2.we = we; bus2.funct3 = f3; bus2.addr = a; bus2.wdata = wd;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((q1.size() != 0 || q2.size() != 0) && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (q1.size() != 0 || q2.size() != 0) begin
      check("idle_timeout", q1.size() + q2.size(), 0);
      q1.delete();
      q2.delete();
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    exp_t e1, e2;
    @(negedge clk);
    e1 = model(we, f3, a, wd, 1, last_rdata);
    e2 = model(we, f3, a, wd, 2, last_rdata);
    e1.t_acc = cyc;
    e2.t_acc = cyc;
    last_rdata = e1.rdata;
    q1.push_back(e1);
    q2.push_back(e2);
    set_req(1'b1, we, f3, a, wd);
    @(negedge clk);
    set_req(1'b0, we, f3, a, wd);
    wait_idle();
  endtask

  // Keep req high until this instance completes, let it be re-accepted in
  // the following IDLE cycle, then drop req
  task automatic hold_watch(input int idx, input exp_t tmpl);
    exp_t e;
    int   k;
    logic seen;
    e    = tmpl;
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      seen = (idx == 0) ? bus1.done : bus2.done;
    end
    check("hold_done_seen", {31'b0, seen}, 32'h1);
    @(negedge clk);
    e.t_acc = cyc;
    if (idx == 0) q1.push_back(e);
    else          q2.push_back(e);
    @(negedge clk);
    if (idx == 0) bus1.req = 1'b0;
    else          bus2.req = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy1"}, {31'b0, bus1.busy}, 32'h0);
    check({tag, "_done1"}, {31'b0, bus1.done}, 32'h0);
    check({tag, "_wen1"},  {31'b0, bus1.mem_wen}, 32'h0);
    check({tag, "_ren1"},  {31'b0, bus1.mem_ren}, 32'h0);
    check({tag, "_rdata1"}, bus1.rdata, 32'h0);
    check({tag, "_busy2"}, {31'b0, bus2.busy}, 32'h0);
    check({tag, "_done2"}, {31'b0, bus2.done}, 32'h0);
    check({tag, "_wen2"},  {31'b0, bus2.mem_wen}, 32'h0);
    check({tag, "_ren2"},  {31'b0, bus2.mem_ren}, 32'h0);
    check({tag, "_rdata2"}, bus2.rdata, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem_words[i] = 32'h0F1E2D3C ^ (i * 32'h01010101);
    mem_words[0] = 32'h80F1E2D3;
    mem_words[1] = 32'h13579BDF;
    mem_words[2] = 32'h80F1E2D3;

    // Reset held with req asserted
    reset_n = 1'b0;
    set_req(1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
    repeat (3) begin
      @(negedge clk);
      check_zero_outputs("rst");
    end
    set_req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed stores
    issue(1'b1, 3'b000, 32'h00000007, 32'h123456AB);
    issue(1'b1, 3'b001, 32'h00000006, 32'h0000BEEF);
    issue(1'b1, 3'b010, 32'h00000008, 32'hCAFEF00D);
    // Directed loads
    issue(1'b0, 3'b001, 32'h0000000A, 32'h0);
    issue(1'b0, 3'b101, 32'h0000000A, 32'h0);
    issue(1'b0, 3'b000, 32'h00000001, 32'h0);
    issue(1'b0, 3'b100, 32'h00000003, 32'h0);
    issue(1'b0, 3'b010, 32'h00000004, 32'h0);
    // Errors
    issue(1'b0, 3'b010, 32'h00000006, 32'h0);
    issue(1'b1, 3'b100, 32'h00000004, 32'h11223344);
    issue(1'b0, 3'b001, 32'h00000005, 32'h0);
    issue(1'b0, 3'b011, 32'h00000000, 32'h0);
    issue(1'b1, 3'b010, 32'h00000002, 32'h55667788);

    // Random mix of legal and illegal accesses
    for (int i = 0; i < 24; i++) begin
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            32'($urandom_range(0, 63)), $urandom);
    end

    // req held high through a load
    @(negedge clk);
    h1 = model(1'b0, 3'b000, 32'h0000000B, 32'h0, 1, last_rdata);
    h2 = model(1'b0, 3'b000, 32'h0000000B, 32'h0, 2, last_rdata);
    h1.t_acc = cyc;
    h2.t_acc = cyc;
    last_rdata = h1.rdata;
    q1.push_back(h1);
    q2.push_back(h2);
    set_req(1'b1, 1'b0, 3'b000, 32'h0000000B, 32'h0);
    fork
      hold_watch(0, h1);
      hold_watch(1, h2);
    join
    wait_idle();

    // Reset asserted while the latency-2 instance sits in WAIT
    @(negedge clk);
    set_req(1'b1, 1'b0, 3'b010, 32'h00000008, 32'h0);
    @(negedge clk);
    set_req(1'b0, 1'b0, 3'b010, 32'h00000008, 32'h0);
    @(negedge clk);
    check("wait_busy2", {31'b0, bus2.busy}, 32'h1);
    check("wait_ren2", {31'b0, bus2.mem_ren}, 32'h0);
    reset_n = 1'b0;
    #1;
    check_zero_outputs("midrst");
    last_rdata = 32'h0;
    nren = '{0, 0};
    nwen = '{0, 0};
    repeat (2) begin
      @(negedge clk);
      check("midrst_done1", {31'b0, bus1.done}, 32'h0);
      check("midrst_done2", {31'b0, bus2.done}, 32'h0);
    end
    reset_n = 1'b1;
    repeat (6) @(negedge clk);

    // Recovery after the abandoned access
    issue(1'b0, 3'b010, 32'h00000004, 32'h0);
    issue(1'b0, 3'b100, 32'h0000000A, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute guard against a stalled run
  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $fatal(1, "global timeout");
  end

endmodule
